// File: rtl/vga_capture_rx.sv
// vga_capture_rx: receive side of the VGA pixel interface.
// Samples sync + 4:4:4 RGB on each pixel tick, recovers beam position from
// sync falling edges, qualifies timing with a SEARCH/MEASURE/LOCKED machine
// and re-emits active pixels with their coordinates.
// Optional build macro VGA_CAPTURE_CHECKSUM_EN adds a per-frame pixel sum
// (frameSum/frameSumValid).
module vga_capture_rx #(
  parameter int H_DISPLAY   = 640,
  parameter int H_BACK      = 48,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_BACK      = 33,
  parameter int V_SYNC      = 2,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2    // 1..15, held in a 4-bit counter
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pTick,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        videoON,
  output logic        pixelValid,
  output logic [11:0] pixelRGB,
  output logic        frameStart,
  output logic        locked,
  output logic        timingError
`ifdef VGA_CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0] frameSum,
  output logic        frameSumValid
`endif
);

  // Active window bounds and check targets, as 10-bit counter values.
  localparam logic [9:0] H_A0    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_A1    = 10'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [9:0] V_A0    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_A1    = 10'(V_SYNC + V_BACK + V_DISPLAY);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // sample stage
  logic        s_hs, s_vs, p_hs, p_vs;
  logic [11:0] s_rgb;
  // beam position of the previously processed sample
  logic [9:0]  h_cnt, v_cnt;
  logic [9:0]  h_next, v_next;
  logic        h_fall, v_fall;
  logic        line_ok, frame_ok, line_bad;
  logic        active, valid_now;
  // lock machine
  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        armed, armed_nx;
  logic        err_set;

  // Sample stage: register the pins each tick, keep the prior sync level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_hs  <= 1'b0;
      s_vs  <= 1'b0;
      p_hs  <= 1'b0;
      p_vs  <= 1'b0;
      s_rgb <= '0;
    end else if (pTick) begin
      p_hs  <= s_hs;
      p_vs  <= s_vs;
      s_hs  <= hSync;
      s_vs  <= vSync;
      s_rgb <= {vgaRed, vgaGreen, vgaBlue};
    end
  end

  assign h_fall = p_hs & ~s_hs;
  assign v_fall = p_vs & ~s_vs;

  // Position of the sample being processed. Both counters saturate so a
  // dead sync line can never alias back into the active window.
  always_comb begin
    h_next = h_fall ? '0 : ((h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1);
    v_next = v_cnt;
    if (v_fall)
      v_next = '0;
    else if (h_fall && (v_cnt != CNT_MAX))
      v_next = v_cnt + 10'd1;
  end

  assign active    = (h_next >= H_A0) && (h_next < H_A1) &&
                     (v_next >= V_A0) && (v_next < V_A1);
  assign valid_now = pTick && active && (state == LOCKED);

  // Completed line/frame lengths are judged from the count before reset-to-0.
  assign line_ok  = (h_cnt == H_LAST);
  assign frame_ok = (v_cnt == V_LAST);
  assign line_bad = h_fall && armed && !line_ok;

  // Beam counters advance once per tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pTick) begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Lock machine state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= SEARCH;
      good  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
      armed <= armed_nx;
    end
  end

  // Lock machine next state. The line check is disarmed in SEARCH so the
  // first line edge after acquiring vSync (possibly a partial line) is exempt.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    armed_nx = armed;
    err_set  = 1'b0;
    if (pTick) begin
      case (state)
        SEARCH: begin
          armed_nx = 1'b0;
          if (v_fall) begin
            state_nx = MEASURE;
            good_nx  = '0;
          end
        end
        MEASURE: begin
          if (h_fall) armed_nx = 1'b1;
          if (line_bad) begin
            state_nx = SEARCH;
          end else if (v_fall) begin
            if (frame_ok) begin
              good_nx = good + 4'd1;
              if (good + 4'd1 == LOCK_N) state_nx = LOCKED;
            end else begin
              good_nx = '0;
            end
          end
        end
        LOCKED: begin
          if (h_fall) armed_nx = 1'b1;
          if (line_bad || (v_fall && !frame_ok) || (h_next == CNT_MAX)) begin
            err_set  = 1'b1;
            state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  // Output register: one tick behind the sample stage; strobes last one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixelX      <= '0;
      pixelY      <= '0;
      videoON     <= 1'b0;
      pixelValid  <= 1'b0;
      pixelRGB    <= '0;
      frameStart  <= 1'b0;
      timingError <= 1'b0;
    end else begin
      pixelValid <= 1'b0;
      frameStart <= 1'b0;
      if (pTick) begin
        videoON    <= active;
        pixelX     <= active ? h_next - H_A0 : '0;
        pixelY     <= active ? v_next - V_A0 : '0;
        pixelValid <= valid_now;
        frameStart <= v_fall;
        if (active) pixelRGB <= s_rgb;
        if (err_set) timingError <= 1'b1;
      end
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] acc;

  // Frame checksum: sum of emitted pixels, handed off at each locked vSync edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc           <= '0;
      frameSum      <= '0;
      frameSumValid <= 1'b0;
    end else begin
      frameSumValid <= 1'b0;
      if (pTick && v_fall && (state == LOCKED)) begin
        frameSum      <= acc;
        frameSumValid <= 1'b1;
        acc           <= valid_now ? 16'(s_rgb) : '0;
      end else if (valid_now) begin
        acc <= acc + 16'(s_rgb);
      end
    end
  end
`endif

endmodule
